// File: rtl/dmem_ctrl_if.sv
// Request/response bundle between the load/store unit and the data memory controller.
interface dmem_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_func3;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_fault;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_func3,
        input  req_ready, resp_valid, resp_rdata, resp_fault
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_func3,
        output req_ready, resp_valid, resp_rdata, resp_fault
    );
endinterface

// File: rtl/dmem_ctrl.sv
// Byte/half/word load-store controller over a word-organised little-endian RAM.
// Word-crossing accesses are split into two word cycles; illegal or out-of-range requests fault.
module dmem_ctrl #(
    parameter int unsigned DEPTH_WORDS      = 256,
    parameter bit          ALLOW_MISALIGNED = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    dmem_ctrl_if.slave  bus
);
    localparam int unsigned AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [32:0] LAST_BYTE = 33'(4 * DEPTH_WORDS) - 33'd1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ACC0  = 3'd1,
        S_ACC1  = 3'd2,
        S_FAULT = 3'd3,
        S_RESP  = 3'd4
    } state_e;

    // Byte lanes touched across the two-word window {word w+1, word w}.
    function automatic logic [7:0] lane_mask(input logic [2:0] f3, input logic [1:0] off);
        logic [3:0] m;
        case (f3[1:0])
            2'd0:    m = 4'b0001;
            2'd1:    m = 4'b0011;
            2'd2:    m = 4'b1111;
            default: m = 4'b0000;
        endcase
        return {4'b0000, m} << off;
    endfunction

    function automatic logic [2:0] size_bytes(input logic [2:0] f3);
        case (f3[1:0])
            2'd0:    return 3'd1;
            2'd1:    return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    function automatic logic legal_f3(input logic we, input logic [2:0] f3);
        return we ? (f3 <= 3'd2) : ((f3 != 3'd3) && (f3 <= 3'd5));
    endfunction

    function automatic logic [31:0] fmt_load(input logic [2:0] f3, input logic [31:0] sh);
        case (f3)
            3'd0:    return {{24{sh[7]}}, sh[7:0]};
            3'd1:    return {{16{sh[15]}}, sh[15:0]};
            3'd2:    return sh;
            3'd4:    return {24'h000000, sh[7:0]};
            3'd5:    return {16'h0000, sh[15:0]};
            default: return 32'h0000_0000;
        endcase
    endfunction

    state_e        state_q, state_d;
    logic          we_q;
    logic [2:0]    f3_q;
    logic [1:0]    off_q;
    logic [AW-1:0] w_q;
    logic [31:0]   wdata_q;
    logic [31:0]   lo_q;
    logic          resp_valid_q, resp_valid_d;
    logic          resp_fault_q, resp_fault_d;
    logic [31:0]   resp_rdata_q, resp_rdata_d;

    logic [31:0]   mem_q [DEPTH_WORDS] = '{default: 32'h0000_0000};

    logic          accept_s;
    logic [7:0]    req_mask_s;
    logic [32:0]   req_last_s;
    logic          req_fault_s;
    logic [7:0]    q_mask_s;
    logic          q_cross_s;
    logic [AW-1:0] idx_s;
    logic [31:0]   rd_word_s;
    logic [63:0]   wide_s;
    logic [3:0]    be_s;
    logic [31:0]   wr_data_s;
    logic          wr_en_s;
    logic [31:0]   lo_s;
    logic [31:0]   hi_s;
    logic [31:0]   load_s;

    assign bus.req_ready  = (state_q == S_IDLE) && !rst;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_fault = resp_fault_q;
    assign bus.resp_rdata = resp_rdata_q;

    assign accept_s    = bus.req_valid && bus.req_ready;
    assign req_mask_s  = lane_mask(bus.req_func3, bus.req_addr[1:0]);
    assign req_last_s  = {1'b0, bus.req_addr} + {30'd0, size_bytes(bus.req_func3)} - 33'd1;
    assign req_fault_s = !legal_f3(bus.req_we, bus.req_func3)
                       || (req_last_s > LAST_BYTE)
                       || ((|req_mask_s[7:4]) && !ALLOW_MISALIGNED);

    assign q_mask_s  = lane_mask(f3_q, off_q);
    assign q_cross_s = |q_mask_s[7:4];
    assign idx_s     = (state_q == S_ACC1) ? (w_q + AW'(1)) : w_q;
    assign rd_word_s = mem_q[idx_s];
    assign wide_s    = {32'h0000_0000, wdata_q} << {off_q, 3'b000};
    assign be_s      = (state_q == S_ACC0) ? q_mask_s[3:0] :
                       (state_q == S_ACC1) ? q_mask_s[7:4] : 4'b0000;
    assign wr_data_s = (state_q == S_ACC1) ? wide_s[63:32] : wide_s[31:0];
    // A reset at the edge closing an ACC state must cancel that write.
    assign wr_en_s   = we_q && !rst && ((state_q == S_ACC0) || (state_q == S_ACC1));

    assign lo_s   = (state_q == S_ACC0) ? rd_word_s : lo_q;
    assign hi_s   = (state_q == S_ACC1) ? rd_word_s : 32'h0000_0000;
    assign load_s = fmt_load(f3_q, 32'({hi_s, lo_s} >> {off_q, 3'b000}));

    // Next-state and registered-response decode.
    always_comb begin
        state_d      = state_q;
        resp_valid_d = 1'b0;
        resp_fault_d = 1'b0;
        resp_rdata_d = 32'h0000_0000;
        case (state_q)
            S_IDLE: begin
                if (accept_s) begin
                    state_d = req_fault_s ? S_FAULT : S_ACC0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ACC0: begin
                if (q_cross_s) begin
                    state_d = S_ACC1;
                end else begin
                    state_d      = S_RESP;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = we_q ? 32'h0000_0000 : load_s;
                end
            end
            S_ACC1: begin
                state_d      = S_RESP;
                resp_valid_d = 1'b1;
                resp_rdata_d = we_q ? 32'h0000_0000 : load_s;
            end
            S_FAULT: begin
                state_d      = S_RESP;
                resp_valid_d = 1'b1;
                resp_fault_d = 1'b1;
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State, request latch and response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            we_q         <= 1'b0;
            f3_q         <= 3'd0;
            off_q        <= 2'd0;
            w_q          <= '0;
            wdata_q      <= 32'h0000_0000;
            lo_q         <= 32'h0000_0000;
            resp_valid_q <= 1'b0;
            resp_fault_q <= 1'b0;
            resp_rdata_q <= 32'h0000_0000;
        end else begin
            state_q      <= state_d;
            resp_valid_q <= resp_valid_d;
            resp_fault_q <= resp_fault_d;
            resp_rdata_q <= resp_rdata_d;
            if (accept_s) begin
                we_q    <= bus.req_we;
                f3_q    <= bus.req_func3;
                off_q   <= bus.req_addr[1:0];
                w_q     <= bus.req_addr[AW+1:2];
                wdata_q <= bus.req_wdata;
            end
            if (state_q == S_ACC0) begin
                lo_q <= rd_word_s;
            end
        end
    end

    // Byte-enable write port; contents survive reset.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (wr_en_s && be_s[b]) begin
                mem_q[idx_s][8*b +: 8] <= wr_data_s[8*b +: 8];
            end
        end
    end
endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench: one controller with misaligned splitting, one with misaligned faulting.
module tb_dmem_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   pulse_bad = 0;

    dmem_ctrl_if bus_a ();
    dmem_ctrl_if bus_b ();

    dmem_ctrl #(.DEPTH_WORDS(256), .ALLOW_MISALIGNED(1'b1)) dut (.clk(clk), .rst(rst), .bus(bus_a));
    dmem_ctrl #(.DEPTH_WORDS(256), .ALLOW_MISALIGNED(1'b0)) dut_na (.clk(clk), .rst(rst), .bus(bus_b));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic drive(input bit sel, input logic v, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [2:0] f3);
        if (sel) begin
            bus_b.req_valid = v; bus_b.req_we = we; bus_b.req_addr = addr;
            bus_b.req_wdata = wdata; bus_b.req_func3 = f3;
        end else begin
            bus_a.req_valid = v; bus_a.req_we = we; bus_a.req_addr = addr;
            bus_a.req_wdata = wdata; bus_a.req_func3 = f3;
        end
    endtask

    // Issues one request, scrambles the inputs after accept, and waits (bounded) for the response.
    task automatic xact(input bit sel, input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [2:0] f3, output logic [31:0] rdata, output logic fault, output int lat);
        logic got;
        @(negedge clk);
        drive(sel, 1'b1, we, addr, wdata, f3);
        @(posedge clk);
        #1;
        drive(sel, 1'b0, ~we, ~addr, ~wdata, 3'd2);
        got = 1'b0; lat = 0; rdata = 32'h0; fault = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (sel ? bus_b.resp_valid : bus_a.resp_valid) begin
                got   = 1'b1;
                rdata = sel ? bus_b.resp_rdata : bus_a.resp_rdata;
                fault = sel ? bus_b.resp_fault : bus_a.resp_fault;
                if (sel ? bus_b.req_ready : bus_a.req_ready) pulse_bad++;
            end
        end
        check("resp_seen", {31'd0, got}, 32'd1);
        @(posedge clk);
        #1;
        if ((sel ? bus_b.resp_valid : bus_a.resp_valid) || !(sel ? bus_b.req_ready : bus_a.req_ready))
            pulse_bad++;
    endtask

    task automatic ld(input bit sel, input string tag, input logic [31:0] addr, input logic [2:0] f3,
                      input logic [31:0] exp, input logic exp_f, input int exp_lat);
        logic [31:0] r; logic f; int l;
        xact(sel, 1'b0, addr, 32'h0, f3, r, f, l);
        check({tag, "_data"}, r, exp);
        check({tag, "_fault"}, {31'd0, f}, {31'd0, exp_f});
        check({tag, "_lat"}, 32'(l), 32'(exp_lat));
    endtask

    task automatic st(input bit sel, input string tag, input logic [31:0] addr, input logic [31:0] data,
                      input logic [2:0] f3, input logic exp_f, input int exp_lat);
        logic [31:0] r; logic f; int l;
        xact(sel, 1'b1, addr, data, f3, r, f, l);
        check({tag, "_data"}, r, 32'h0);
        check({tag, "_fault"}, {31'd0, f}, {31'd0, exp_f});
        check({tag, "_lat"}, 32'(l), 32'(exp_lat));
    endtask

    initial begin
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'd0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 3'd0);
        repeat (3) @(posedge clk);
        #1;
        check("ready_in_rst", {31'd0, bus_a.req_ready}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_ready", {31'd0, bus_a.req_ready}, 32'd1);
        check("rst_valid", {31'd0, bus_a.resp_valid}, 32'd0);
        check("rst_fault", {31'd0, bus_a.resp_fault}, 32'd0);
        check("rst_rdata", bus_a.resp_rdata, 32'h0);

        st(1'b0, "sw10",   32'h10, 32'hDEADBEEF, 3'd2, 1'b0, 1);
        ld(1'b0, "lw10",   32'h10, 3'd2, 32'hDEADBEEF, 1'b0, 1);
        ld(1'b0, "lb13",   32'h13, 3'd0, 32'hFFFFFFDE, 1'b0, 1);
        ld(1'b0, "lbu13",  32'h13, 3'd4, 32'h000000DE, 1'b0, 1);
        ld(1'b0, "lh12",   32'h12, 3'd1, 32'hFFFFDEAD, 1'b0, 1);
        ld(1'b0, "lhu12",  32'h12, 3'd5, 32'h0000DEAD, 1'b0, 1);
        ld(1'b0, "lh13x",  32'h13, 3'd1, 32'h000000DE, 1'b0, 2);

        st(1'b0, "sw21",   32'h21, 32'h11223344, 3'd2, 1'b0, 2);
        ld(1'b0, "lw20",   32'h20, 3'd2, 32'h22334400, 1'b0, 1);
        ld(1'b0, "lw24",   32'h24, 3'd2, 32'h00000011, 1'b0, 1);
        ld(1'b0, "lw21",   32'h21, 3'd2, 32'h11223344, 1'b0, 2);
        ld(1'b0, "lhu23",  32'h23, 3'd5, 32'h00001122, 1'b0, 2);

        ld(1'b0, "lw3fc",  32'h3FC, 3'd2, 32'h0, 1'b0, 1);
        ld(1'b0, "lw3fd",  32'h3FD, 3'd2, 32'h0, 1'b1, 1);
        st(1'b0, "sb400",  32'h400, 32'h000000AA, 3'd0, 1'b1, 1);
        ld(1'b0, "lw0",    32'h0, 3'd2, 32'h0, 1'b0, 1);

        ld(1'b0, "ldf3",   32'h10, 3'd3, 32'h0, 1'b1, 1);
        ld(1'b0, "ldf7",   32'h10, 3'd7, 32'h0, 1'b1, 1);
        st(1'b0, "stf4",   32'h10, 32'h12345678, 3'd4, 1'b1, 1);
        ld(1'b0, "lw10b",  32'h10, 3'd2, 32'hDEADBEEF, 1'b0, 1);

        st(1'b1, "na_sw4", 32'h04, 32'h01020304, 3'd2, 1'b0, 1);
        st(1'b1, "na_sh7", 32'h07, 32'h0000BEEF, 3'd1, 1'b1, 1);
        ld(1'b1, "na_lw4", 32'h04, 3'd2, 32'h01020304, 1'b0, 1);

        // Crossing store aborted by reset while its second word is in flight.
        st(1'b0, "sw34",   32'h34, 32'hCAFEF00D, 3'd2, 1'b0, 1);
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b1, 32'h31, 32'hA1B2C3D4, 3'd2);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort_valid0", {31'd0, bus_a.resp_valid}, 32'd0);
        @(posedge clk);
        #1;
        check("abort_valid1", {31'd0, bus_a.resp_valid}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort_ready", {31'd0, bus_a.req_ready}, 32'd1);
        check("abort_valid2", {31'd0, bus_a.resp_valid}, 32'd0);
        ld(1'b0, "abort_lw30", 32'h30, 3'd2, 32'hB2C3D400, 1'b0, 1);
        ld(1'b0, "abort_lw34", 32'h34, 3'd2, 32'hCAFEF00D, 1'b0, 1);

        check("pulse_shape", 32'(pulse_bad), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
